// File: rtl/uart_rx.sv
// 8N1 UART receiver with two-flop input synchroniser, mid-bit sampling and glitch/framing rejection.
// Optional even-parity bit (8E1) when UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    if (CLKS_PER_BIT < 4) begin : g_bad_cfg
        $error("uart_rx: CLKS_PER_BIT must be >= 4");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t        state, state_next;
    logic          rx_meta, rx_s;
    logic [CW-1:0] clk_cnt, clk_cnt_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    shift_reg, shift_next;
    logic [7:0]    data_next;
    logic          valid_next, frame_err_next;
`ifdef UART_RX_PARITY_EN
    logic          par_bad, par_bad_next;
    logic          parity_err_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            clk_cnt    <= clk_cnt_next;
            bit_idx    <= bit_idx_next;
            shift_reg  <= shift_next;
            data       <= data_next;
            valid      <= valid_next;
            frame_err  <= frame_err_next;
            busy       <= (state_next != IDLE);
`ifdef UART_RX_PARITY_EN
            par_bad    <= par_bad_next;
            parity_err <= parity_err_next;
`endif
        end
    end

    always_comb begin
        state_next   = state;
        clk_cnt_next = clk_cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift_reg;
`ifdef UART_RX_PARITY_EN
        par_bad_next = par_bad;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next   = START;
                    clk_cnt_next = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_next = 1'b0;
`endif
                end
            end
            START: begin
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_next = '0;
                    bit_idx_next = '0;
                    // A line already back high at mid-start was only a glitch.
                    state_next   = rx_s ? IDLE : DATA;
                end else begin
                    clk_cnt_next = clk_cnt + ONE;
                end
            end
            DATA: begin
                if (clk_cnt == LAST) begin
                    clk_cnt_next = '0;
                    shift_next   = {rx_s, shift_reg[7:1]};
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (clk_cnt == LAST) begin
                    clk_cnt_next = '0;
                    par_bad_next = ^{shift_reg, rx_s};
                    state_next   = STOP;
                end else begin
                    clk_cnt_next = clk_cnt + ONE;
                end
            end
`endif
            STOP: begin
                if (clk_cnt == LAST) begin
                    clk_cnt_next = '0;
                    state_next   = rx_s ? IDLE : BREAK;
                end else begin
                    clk_cnt_next = clk_cnt + ONE;
                end
            end
            BREAK: begin
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        valid_next      = 1'b0;
        frame_err_next  = 1'b0;
        data_next       = data;
`ifdef UART_RX_PARITY_EN
        parity_err_next = 1'b0;
`endif
        if (state == STOP && clk_cnt == LAST) begin
            // A low stop bit wins over any parity result.
            if (!rx_s) begin
                frame_err_next = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            else if (par_bad) begin
                parity_err_next = 1'b1;
            end
`endif
            else begin
                valid_next = 1'b1;
                data_next  = shift_reg;
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; parity scenario only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

    localparam int CPB = 16;
    // rx is driven on a negedge; rx_s falls two posedges later, valid 153 after that.
    localparam int LAT_BASE = 2 + CPB / 2 + 9 * CPB + 1;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = LAT_BASE + CPB;
`else
    localparam int LAT = LAT_BASE;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       valid, frame_err, parity_err, busy;

    int checks = 0;
    int errors = 0;

    int         cyc = 0;
    int         n_valid = 0, n_ferr = 0, n_perr = 0;
    int         last_valid_cyc = 0, last_ferr_cyc = 0;
    logic [7:0] last_valid_data = '0;
    logic       busy_at_valid = 1'b1;

    uart_rx #(.CLK_HZ(1_600_000), .BAUD(100_000)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .data(data), .valid(valid),
        .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) begin
                n_valid++;
                last_valid_cyc  = cyc;
                last_valid_data = data;
                busy_at_valid   = busy;
            end
            if (frame_err) begin
                n_ferr++;
                last_ferr_cyc = cyc;
            end
            if (parity_err) n_perr++;
        end
    end

    task automatic send_frame(input logic [7:0] b, input int par, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (par >= 0) begin
            rx = par[0];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        checks++; if (busy !== 1'b0 || data !== 8'h00) begin errors++; $display("FAIL idle_outputs: busy=%b data=%h expected 0/00", busy, data); end
        checks++; if (n_valid + n_ferr + n_perr !== 0) begin errors++; $display("FAIL idle_pulses: got %0d expected 0", n_valid + n_ferr + n_perr); end
    endtask

    task automatic test_single_byte;
        int c0, v0, f0;
        c0 = cyc; v0 = n_valid; f0 = n_ferr;
        fork
            send_frame(8'hA5, -1, 1'b1);
            begin
                repeat (20) @(negedge clk);
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid_frame: got %b expected 1", busy); end
            end
        join
        repeat (20) @(negedge clk);
        checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL a5_valid_count: got %0d expected 1", n_valid - v0); end
        checks++; if (last_valid_data !== 8'hA5 || data !== 8'hA5) begin errors++; $display("FAIL a5_data: got %h/%h expected a5", last_valid_data, data); end
        checks++; if (last_valid_cyc - c0 !== LAT_BASE) begin errors++; $display("FAIL a5_latency: got %0d expected %0d", last_valid_cyc - c0, LAT_BASE); end
        checks++; if (busy_at_valid !== 1'b0) begin errors++; $display("FAIL a5_busy_at_valid: got %b expected 0", busy_at_valid); end
        checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL a5_frame_err: got %0d expected 0", n_ferr - f0); end
    endtask

    task automatic test_back_to_back;
        int c1, v0, f0;
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h03, -1, 1'b1);
        checks++; if (last_valid_data !== 8'h03) begin errors++; $display("FAIL b2b_first_data: got %h expected 03", last_valid_data); end
        c1 = cyc;
        send_frame(8'hFF, -1, 1'b1);
        repeat (20) @(negedge clk);
        checks++; if (n_valid - v0 !== 2) begin errors++; $display("FAIL b2b_valid_count: got %0d expected 2", n_valid - v0); end
        checks++; if (data !== 8'hFF) begin errors++; $display("FAIL b2b_second_data: got %h expected ff", data); end
        checks++; if (last_valid_cyc - c1 !== LAT_BASE) begin errors++; $display("FAIL b2b_second_latency: got %0d expected %0d", last_valid_cyc - c1, LAT_BASE); end
        checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL b2b_frame_err: got %0d expected 0", n_ferr - f0); end
    endtask

    task automatic test_glitch;
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b expected 1", busy); end
        @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b expected 0", busy); end
        checks++; if (n_valid - v0 !== 0 || n_ferr - f0 !== 0) begin errors++; $display("FAIL glitch_pulses: valid=%0d frame_err=%0d expected 0/0", n_valid - v0, n_ferr - f0); end
    endtask

    task automatic test_frame_err;
        int c0, v0, f0;
        c0 = cyc; v0 = n_valid; f0 = n_ferr;
        send_frame(8'h55, -1, 1'b0);
        repeat (200) @(negedge clk);
        checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", n_ferr - f0); end
        checks++; if (last_ferr_cyc - c0 !== LAT_BASE) begin errors++; $display("FAIL ferr_timing: got %0d expected %0d", last_ferr_cyc - c0, LAT_BASE); end
        checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL ferr_no_valid: got %0d expected 0", n_valid - v0); end
        checks++; if (data !== 8'hFF) begin errors++; $display("FAIL ferr_data_held: got %h expected ff", data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_in_break: got %b expected 1", busy); end
        rx = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_sync_delay: got %b expected 1", busy); end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release: got %b expected 0", busy); end
        checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL ferr_single: got %0d expected 1", n_ferr - f0); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int c0, v0, p0;
        v0 = n_valid; p0 = n_perr;
        send_frame(8'h07, 0, 1'b1);
        repeat (20) @(negedge clk);
        checks++; if (n_perr - p0 !== 1) begin errors++; $display("FAIL par_bad_count: got %0d expected 1", n_perr - p0); end
        checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL par_bad_no_valid: got %0d expected 0", n_valid - v0); end
        checks++; if (data !== 8'hFF) begin errors++; $display("FAIL par_bad_data_held: got %h expected ff", data); end
        c0 = cyc;
        send_frame(8'h07, 1, 1'b1);
        repeat (20) @(negedge clk);
        checks++; if (n_valid - v0 !== 1 || data !== 8'h07) begin errors++; $display("FAIL par_good: valid=%0d data=%h expected 1/07", n_valid - v0, data); end
        checks++; if (last_valid_cyc - c0 !== LAT) begin errors++; $display("FAIL par_good_latency: got %0d expected %0d", last_valid_cyc - c0, LAT); end
        checks++; if (n_perr - p0 !== 1) begin errors++; $display("FAIL par_good_no_perr: got %0d expected 1", n_perr - p0); end
    endtask
`endif

    task automatic run_default_frames;
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_frame_err();
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        @(negedge clk);
        test_reset();
`ifdef UART_RX_PARITY_EN
        test_glitch();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'hFF, 0, 1'b1);
        repeat (20) @(negedge clk);
        checks++; if (data !== 8'hFF) begin errors++; $display("FAIL par_ff_data: got %h expected ff", data); end
        test_parity();
`else
        run_default_frames();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
